dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port 4096x32 data RAM between the processor's dmem port (port C) and the
//  sonar sample engine (port S). Grants one access per cycle, routes synchronous read data back
//  to the requester that issued it, and bounds sonar wait time with a starvation counter.
//  Sits between the processor/sonar engine and the RAM inside the top-level wrapper.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive denied sonar cycles before sonar takes priority (>=1)
//  CNT_W         16  width of the saturating sonar-grant statistics counter
// PORTS
//  clock        in   1      system clock, all state updates on rising edge
//  reset        in   1      asynchronous, active-low reset (0 = reset asserted)
//  cpu_req      in   1      processor requests RAM access this cycle
//  cpu_we       in   1      1 = write, 0 = read
//  cpu_addr     in   12     word address
//  cpu_wdata    in   32     write data
//  cpu_gnt      out  1      access accepted this cycle (combinational)
//  cpu_rvalid   out  1      read data for processor present this cycle
//  cpu_rdata    out  32     read data; 0 when cpu_rvalid=0
//  snr_req/snr_we/snr_addr[11:0]/snr_wdata[31:0]   in    same meaning, sonar side
//  snr_gnt/snr_rvalid/snr_rdata[31:0]              out   same meaning, sonar side
//  ram_wen      out  1      RAM write enable
//  ram_addr     out  12     RAM address
//  ram_din      out  32     RAM write data
//  ram_dout     in   32     RAM read data, valid the cycle after the address is presented
//  snr_grants   out  CNT_W  saturating count of sonar grants since reset
// BEHAVIOUR
//  - Reset (reset=0): cpu_gnt, snr_gnt, ram_wen, both rvalid forced 0; rdata 0; ram_addr/ram_din 0;
//    wait_cnt=0, snr_grants=0, return state=IDLE. Pending read return is discarded.
//  - Arbitration (comb, per cycle): at most one gnt high. Default priority C > S.
//    If snr_req && wait_cnt>=STARVE_LIMIT, S wins over C that cycle.
//  - wait_cnt: +1 each cycle snr_req=1 && snr_gnt=0 (saturates at STARVE_LIMIT);
//    cleared on snr_gnt=1 or snr_req=0.
//  - RAM mux: granted port's we/addr/wdata drive ram_wen/ram_addr/ram_din; no grant -> ram_wen=0,
//    addr/din hold 0. ram_wen never high without a grant.
//  - Return FSM (registered, next state set from the current cycle's grant):
//    IDLE    -> RD_C on cpu read grant, RD_S on snr read grant, else IDLE (writes -> IDLE).
//    RD_C    -> cpu_rvalid=1, cpu_rdata=ram_dout; next per this cycle's grant.
//    RD_S    -> snr_rvalid=1, snr_rdata=ram_dout; next per this cycle's grant.
//    Read latency = 1 cycle after gnt. Back-to-back reads, including alternating ports,
//    run at one per cycle. Data never reaches the non-issuing port.
//  - A requester holds req/we/addr/wdata stable until it sees gnt; gnt=0 means retry next cycle
//    (processor treats cpu_req && !cpu_gnt as a stall).
//  - Read and write to the same address in consecutive cycles: the read issued first returns old
//    data; a read issued after a write returns the new data.
//  - snr_grants: +1 per snr_gnt, saturates at 2^CNT_W-1.
//  - Addresses are 12-bit. Word 0xFFF is the last word; there is no wrap logic (callers supply
//    12 bits).
// TESTING
//  1 reset=0 with cpu_req=snr_req=1 -> both gnt=0, ram_wen=0, rvalid=0. Release reset -> cpu_gnt=1 same cycle.
//  2 CPU write 0x010<=0xDEADBEEF, then CPU read 0x010 -> cpu_rvalid=1 exactly 1 cycle after gnt,
//    cpu_rdata=0xDEADBEEF, snr_rvalid stays 0.
//  3 cpu_req held, snr_req held (STARVE_LIMIT=4) -> cpu_gnt cycles 0-3, snr_gnt at cycle 4 with cpu_gnt=0,
//    cpu_gnt resumes at cycle 5, snr_grants=1.
//  4 Preload 0x100=0xA, 0x200=0xB; alternating C read 0x100 / S read 0x200 every cycle -> cpu_rdata=0xA and
//    snr_rdata=0xB on the correct port each time, no cross-delivery.
//  5 CPU read granted, reset pulled low next cycle -> cpu_rvalid=0, cpu_rdata=0; after release, FSM is IDLE.
//  6 S write 0xFFF<=0x12345678, then C read 0xFFF -> cpu_rdata=0x12345678; word 0x000 is unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port 4096x32 data RAM: processor (C) and sonar engine (S).
// Grants one access per cycle, steers synchronous read data back to the issuing port and
// bounds sonar wait time with a starvation counter.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [11:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_rvalid,
  output logic [31:0]      cpu_rdata,
  input  logic             snr_req,
  input  logic             snr_we,
  input  logic [11:0]      snr_addr,
  input  logic [31:0]      snr_wdata,
  output logic             snr_gnt,
  output logic             snr_rvalid,
  output logic [31:0]      snr_rdata,
  output logic             ram_wen,
  output logic [11:0]      ram_addr,
  output logic [31:0]      ram_din,
  input  logic [31:0]      ram_dout,
  output logic [CNT_W-1:0] snr_grants
);

  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_C = 2'd1,
    RD_S = 2'd2
  } ret_state_t;

  ret_state_t        state_q;
  ret_state_t        state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              starve;

  assign starve = (wait_cnt >= WAIT_W'(STARVE_LIMIT));

  // Arbitration: processor first unless the sonar has waited STARVE_LIMIT cycles.
  always_comb begin
    cpu_gnt = 1'b0;
    snr_gnt = 1'b0;
    if (reset) begin
      if (snr_req && starve) begin
        snr_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (snr_req) begin
        snr_gnt = 1'b1;
      end
    end
  end

  // RAM command mux: only the granted port reaches the RAM, otherwise all zero.
  always_comb begin
    ram_wen  = 1'b0;
    ram_addr = 12'd0;
    ram_din  = 32'd0;
    if (cpu_gnt) begin
      ram_wen  = cpu_we;
      ram_addr = cpu_addr;
      ram_din  = cpu_wdata;
    end else if (snr_gnt) begin
      ram_wen  = snr_we;
      ram_addr = snr_addr;
      ram_din  = snr_wdata;
    end
  end

  // Sonar wait counter: counts denied request cycles, saturates at the starvation limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!snr_req || snr_gnt) begin
      wait_cnt <= '0;
    end else if (!starve) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Saturating statistics counter of sonar grants.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snr_grants <= '0;
    end else if (snr_gnt && (snr_grants != {CNT_W{1'b1}})) begin
      snr_grants <= snr_grants + CNT_W'(1);
    end
  end

  // Return FSM state register; a reset discards any read still in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows this cycle's grant so reads pipeline at one per cycle.
  always_comb begin
    state_d = IDLE;
    if (cpu_gnt && !cpu_we) begin
      state_d = RD_C;
    end else if (snr_gnt && !snr_we) begin
      state_d = RD_S;
    end
  end

  // Read return steering: RAM output reaches only the port that issued the read.
  always_comb begin
    cpu_rvalid = 1'b0;
    cpu_rdata  = 32'd0;
    snr_rvalid = 1'b0;
    snr_rdata  = 32'd0;
    case (state_q)
      RD_C: begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = ram_dout;
      end
      RD_S: begin
        snr_rvalid = 1'b1;
        snr_rdata  = ram_dout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM behavioural model, per-cycle scoreboard monitor and
// scenario tasks with their own inline checks.
module tb_dmem_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic          cpu_req, cpu_we, snr_req, snr_we;
  logic [11:0]   cpu_addr, snr_addr;
  logic [31:0]   cpu_wdata, snr_wdata;
  logic          cpu_gnt, cpu_rvalid, snr_gnt, snr_rvalid;
  logic [31:0]   cpu_rdata, snr_rdata;
  logic          ram_wen;
  logic [11:0]   ram_addr;
  logic [31:0]   ram_din, ram_dout;
  logic [CW-1:0] snr_grants;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];
  logic [31:0] cpu_q [$];
  logic [31:0] snr_q [$];
  int          wait_m = 0;
  int          cnt_m  = 0;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .snr_req(snr_req), .snr_we(snr_we), .snr_addr(snr_addr), .snr_wdata(snr_wdata),
    .snr_gnt(snr_gnt), .snr_rvalid(snr_rvalid), .snr_rdata(snr_rdata),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .snr_grants(snr_grants)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port synchronous RAM model.
  always @(posedge clock) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Scoreboard monitor: reference arbitration, RAM mux, read return and grant counter.
  always @(negedge clock) begin
    logic exp_c, exp_s, exp_cv, exp_sv;
    logic [31:0] exp_cd, exp_sd;
    if (!reset) begin
      checks++;
      if (cpu_gnt !== 1'b0 || snr_gnt !== 1'b0 || ram_wen !== 1'b0 || cpu_rvalid !== 1'b0 ||
          snr_rvalid !== 1'b0 || cpu_rdata !== 32'd0 || snr_rdata !== 32'd0 || snr_grants !== '0) begin
        errors++;
        $display("FAIL mon_in_reset: gnt=%b%b wen=%b rv=%b%b rd=%h/%h cnt=%0d, required all zero",
                 cpu_gnt, snr_gnt, ram_wen, cpu_rvalid, snr_rvalid, cpu_rdata, snr_rdata, snr_grants);
      end
      cpu_q.delete();
      snr_q.delete();
      wait_m = 0;
      cnt_m  = 0;
    end else begin
      exp_c = cpu_req && !(snr_req && wait_m >= int'(LIMIT));
      exp_s = snr_req && !exp_c;
      checks++;
      if (cpu_gnt !== exp_c || snr_gnt !== exp_s) begin
        errors++;
        $display("FAIL mon_gnt: cpu_gnt=%b snr_gnt=%b, required %b %b", cpu_gnt, snr_gnt, exp_c, exp_s);
      end
      checks++;
      if (exp_c) begin
        if (ram_wen !== cpu_we || ram_addr !== cpu_addr || ram_din !== cpu_wdata) begin
          errors++;
          $display("FAIL mon_ram_cpu: wen=%b addr=%h din=%h, required %b %h %h",
                   ram_wen, ram_addr, ram_din, cpu_we, cpu_addr, cpu_wdata);
        end
      end else if (exp_s) begin
        if (ram_wen !== snr_we || ram_addr !== snr_addr || ram_din !== snr_wdata) begin
          errors++;
          $display("FAIL mon_ram_snr: wen=%b addr=%h din=%h, required %b %h %h",
                   ram_wen, ram_addr, ram_din, snr_we, snr_addr, snr_wdata);
        end
      end else if (ram_wen !== 1'b0 || ram_addr !== 12'd0 || ram_din !== 32'd0) begin
        errors++;
        $display("FAIL mon_ram_idle: wen=%b addr=%h din=%h, required 0 0 0", ram_wen, ram_addr, ram_din);
      end
      exp_cv = (cpu_q.size() > 0);
      exp_cd = exp_cv ? cpu_q.pop_front() : 32'd0;
      exp_sv = (snr_q.size() > 0);
      exp_sd = exp_sv ? snr_q.pop_front() : 32'd0;
      checks++;
      if (cpu_rvalid !== exp_cv || cpu_rdata !== exp_cd) begin
        errors++;
        $display("FAIL mon_cpu_ret: rvalid=%b rdata=%h, required %b %h", cpu_rvalid, cpu_rdata, exp_cv, exp_cd);
      end
      checks++;
      if (snr_rvalid !== exp_sv || snr_rdata !== exp_sd) begin
        errors++;
        $display("FAIL mon_snr_ret: rvalid=%b rdata=%h, required %b %h", snr_rvalid, snr_rdata, exp_sv, exp_sd);
      end
      checks++;
      if (snr_grants !== CW'(cnt_m)) begin
        errors++;
        $display("FAIL mon_snr_grants: got %0d, required %0d", snr_grants, cnt_m);
      end
      if (exp_c && !cpu_we) cpu_q.push_back(ref_mem[cpu_addr]);
      if (exp_c && cpu_we)  ref_mem[cpu_addr] = cpu_wdata;
      if (exp_s && !snr_we) snr_q.push_back(ref_mem[snr_addr]);
      if (exp_s && snr_we)  ref_mem[snr_addr] = snr_wdata;
      if (snr_req && !exp_s) wait_m = (wait_m < int'(LIMIT)) ? wait_m + 1 : wait_m;
      else                   wait_m = 0;
      if (exp_s && cnt_m < CMAX) cnt_m++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [11:0] ca, input logic [31:0] cd,
                       input logic sr, input logic sw, input logic [11:0] sa, input logic [31:0] sd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    snr_req = sr; snr_we = sw; snr_addr = sa; snr_wdata = sd;
  endtask

  task automatic do_reset();
    drive(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    drive(1, 0, 12'h001, 32'h0, 1, 0, 12'h002, 32'h0);
    @(negedge clock);
    checks++;
    if (cpu_gnt !== 1'b0 || snr_gnt !== 1'b0 || ram_wen !== 1'b0 || cpu_rvalid !== 1'b0 || snr_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b wen=%b rv=%b%b, required 0", cpu_gnt, snr_gnt, ram_wen, cpu_rvalid, snr_rvalid);
    end
    tick();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (cpu_gnt !== 1'b1 || snr_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_gnt: cpu_gnt=%b snr_gnt=%b, required 1 0", cpu_gnt, snr_gnt);
    end
    tick();
    drive(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
    @(negedge clock);
    tick();
  endtask

  task automatic test_cpu_rw();
    drive(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 12'h0, 32'h0);
    tick();
    drive(1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0);
    @(negedge clock);
    checks++;
    if (cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_issue: gnt=%b rvalid=%b, required 1 0", cpu_gnt, cpu_rvalid);
    end
    tick();
    drive(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
    @(negedge clock);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || snr_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_data: rvalid=%b rdata=%h snr_rvalid=%b, required 1 deadbeef 0",
               cpu_rvalid, cpu_rdata, snr_rvalid);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic exp_cg [6] = '{1, 1, 1, 1, 0, 1};
    do_reset();
    drive(1, 0, 12'h020, 32'h0, 1, 0, 12'h030, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      checks++;
      if (cpu_gnt !== exp_cg[k] || snr_gnt !== !exp_cg[k]) begin
        errors++;
        $display("FAIL starve_cycle%0d: cpu_gnt=%b snr_gnt=%b, required %b %b",
                 k, cpu_gnt, snr_gnt, exp_cg[k], !exp_cg[k]);
      end
      tick();
    end
    drive(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
    @(negedge clock);
    checks++;
    if (snr_grants !== CW'(1)) begin
      errors++;
      $display("FAIL starve_grants: got %0d, required 1", snr_grants);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 12'h100, 32'hA, 0, 0, 12'h0, 32'h0);
    tick();
    drive(0, 0, 12'h0, 32'h0, 1, 1, 12'h200, 32'hB);
    tick();
    for (int i = 0; i <= 8; i++) begin
      if (i == 8)          drive(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
      else if (i % 2 == 0) drive(1, 0, 12'h100, 32'h0, 0, 0, 12'h0, 32'h0);
      else                 drive(0, 0, 12'h0, 32'h0, 1, 0, 12'h200, 32'h0);
      @(negedge clock);
      if (i > 0) begin
        checks++;
        if ((i - 1) % 2 == 0) begin
          if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hA || snr_rvalid !== 1'b0 || snr_rdata !== 32'd0) begin
            errors++;
            $display("FAIL b2b_cpu%0d: c=%b/%h s=%b/%h, required 1/a 0/0", i, cpu_rvalid, cpu_rdata, snr_rvalid, snr_rdata);
          end
        end else if (snr_rvalid !== 1'b1 || snr_rdata !== 32'hB || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'd0) begin
          errors++;
          $display("FAIL b2b_snr%0d: c=%b/%h s=%b/%h, required 0/0 1/b", i, cpu_rvalid, cpu_rdata, snr_rvalid, snr_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_abort();
    drive(1, 0, 12'h100, 32'h0, 0, 0, 12'h0, 32'h0);
    @(negedge clock);
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL abort_issue: cpu_gnt=%b, required 1", cpu_gnt);
    end
    tick();
    drive(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'd0) begin
      errors++;
      $display("FAIL abort_discard: rvalid=%b rdata=%h, required 0 0", cpu_rvalid, cpu_rdata);
    end
    tick();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (cpu_rvalid !== 1'b0 || snr_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: rvalid=%b%b, required 00", cpu_rvalid, snr_rvalid);
    end
    tick();
  endtask

  task automatic test_top_word();
    drive(0, 0, 12'h0, 32'h0, 1, 1, 12'hFFF, 32'h12345678);
    tick();
    drive(1, 0, 12'hFFF, 32'h0, 0, 0, 12'h0, 32'h0);
    tick();
    drive(1, 0, 12'h000, 32'h0, 0, 0, 12'h0, 32'h0);
    @(negedge clock);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL top_word_read: rvalid=%b rdata=%h, required 1 12345678", cpu_rvalid, cpu_rdata);
    end
    tick();
    drive(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
    @(negedge clock);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'd0) begin
      errors++;
      $display("FAIL word0_unchanged: rvalid=%b rdata=%h, required 1 0", cpu_rvalid, cpu_rdata);
    end
    tick();
  endtask

  task automatic test_grant_saturate();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 12'h0, 32'h0, 1, 1, 12'h300 + 12'(i), 32'(i));
      tick();
    end
    drive(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
    @(negedge clock);
    checks++;
    if (snr_grants !== CW'(CMAX)) begin
      errors++;
      $display("FAIL grants_saturate: got %0d, required %0d", snr_grants, CMAX);
    end
    tick();
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      mem[a]     = 32'd0;
      ref_mem[a] = 32'd0;
    end
    reset = 1'b0;
    drive(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
    test_reset();
    test_cpu_rw();
    test_starvation();
    test_back_to_back();
    test_reset_abort();
    test_top_word();
    test_grant_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
